// File: rtl/dic_ctrl_if.sv
// dic_ctrl_if: command, keypad and load-pulse bundle between the keypad front end and dic_ctrl.
interface dic_ctrl_if;
  logic cmd_run, cmd_stop, cmd_load, cmd_alarm, cmd_abort, cmd_ack, cmd_next;
  logic key_strb;
  logic [3:0] key_digit;
  logic i_oneSecStrb, alarm_triggered;
  logic ldMtens, ldMones, ldStens, ldSones;
  logic aMtens, aMones, aStens, aSones;
  logic [3:0] ld_num;
  logic dicRun, alarm_ena, dicSelectLEDdisp, err_digit;
  modport master (
    output cmd_run, cmd_stop, cmd_load, cmd_alarm, cmd_abort, cmd_ack, cmd_next,
           key_strb, key_digit, i_oneSecStrb, alarm_triggered,
    input  ldMtens, ldMones, ldStens, ldSones, aMtens, aMones, aStens, aSones,
           ld_num, dicRun, alarm_ena, dicSelectLEDdisp, err_digit
  );
  modport slave (
    input  cmd_run, cmd_stop, cmd_load, cmd_alarm, cmd_abort, cmd_ack, cmd_next,
           key_strb, key_digit, i_oneSecStrb, alarm_triggered,
    output ldMtens, ldMones, ldStens, ldSones, aMtens, aMones, aStens, aSones,
           ld_num, dicRun, alarm_ena, dicSelectLEDdisp, err_digit
  );
endinterface

// File: rtl/dic_ctrl.sv
// dic_ctrl: digital-clock control FSM for run/stop, time and alarm digit entry, and alarm auto-disarm.
module dic_ctrl (
  input logic clk,
  input logic rst,
  dic_ctrl_if.slave bus
);
  localparam logic [3:0] STOP  = 4'd0;
  localparam logic [3:0] RUN   = 4'd1;
  localparam logic [3:0] LT_MT = 4'd2;
  localparam logic [3:0] LT_MO = 4'd3;
  localparam logic [3:0] LT_ST = 4'd4;
  localparam logic [3:0] LT_SO = 4'd5;
  localparam logic [3:0] LA_MT = 4'd6;
  localparam logic [3:0] LA_MO = 4'd7;
  localparam logic [3:0] LA_ST = 4'd8;
  localparam logic [3:0] LA_SO = 4'd9;
  logic [3:0] state, stateN, home;
  logic [4:0] cnt;
  logic [1:0] idx;
  logic retRun, retRunN, inLt, inLa, inLoad, idle, abortC, loadC, alarmC;
  logic legal, keyOk, keyBad, lastDig, laDone, inc, hit, alarmEnaN, dicRunN;
  always_comb begin
    inLt = state >= LT_MT && state <= LT_SO;
    inLa = state >= LA_MT && state <= LA_SO;
    inLoad = inLt | inLa;
    idle = state == STOP || state == RUN;
    abortC = bus.cmd_abort & inLoad;
    loadC = bus.cmd_load & idle;
    alarmC = bus.cmd_alarm & idle & ~bus.cmd_load;
    idx = inLt ? 2'(state - LT_MT) : 2'(state - LA_MT);
    legal = bus.key_digit <= (idx[0] ? 4'd9 : 4'd5);
    keyOk = bus.key_strb & inLoad & ~abortC & legal;
    keyBad = bus.key_strb & inLoad & ~abortC & ~legal;
    lastDig = idx == 2'd3;
    laDone = keyOk & inLa & lastDig;
    home = retRun ? RUN : STOP;
    stateN = abortC ? (inLa ? home : STOP) :
             loadC ? LT_MT :
             alarmC ? LA_MT :
             keyOk ? (lastDig ? (inLa ? home : STOP) : state + 4'd1) :
             (state == STOP && bus.cmd_run) ? RUN :
             (state == RUN && bus.cmd_stop) ? STOP : state;
    retRunN = alarmC ? state == RUN : retRun;
    dicRunN = stateN == RUN || (stateN >= LA_MT && retRunN);
    inc = bus.alarm_ena & bus.alarm_triggered & bus.i_oneSecStrb;
    hit = inc && cnt == 5'd29;
    // completion re-arms even if ack or the timeout land in the same cycle
    alarmEnaN = laDone | (bus.alarm_ena & ~bus.cmd_ack & ~hit);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= STOP;
      retRun <= 1'b0;
      cnt <= 5'd0;
      bus.dicRun <= 1'b0;
      bus.alarm_ena <= 1'b0;
      bus.ld_num <= 4'd0;
      {bus.ldMtens, bus.ldMones, bus.ldStens, bus.ldSones} <= 4'd0;
      {bus.aMtens, bus.aMones, bus.aStens, bus.aSones} <= 4'd0;
      bus.dicSelectLEDdisp <= 1'b0;
      bus.err_digit <= 1'b0;
    end else begin
      state <= stateN;
      retRun <= retRunN;
      cnt <= (bus.alarm_ena & alarmEnaN & ~hit) ? cnt + 5'(inc) : 5'd0;
      bus.dicRun <= dicRunN;
      bus.alarm_ena <= alarmEnaN;
      bus.ld_num <= keyOk ? bus.key_digit : 4'd0;
      bus.ldMtens <= keyOk & inLt & idx == 2'd0;
      bus.ldMones <= keyOk & inLt & idx == 2'd1;
      bus.ldStens <= keyOk & inLt & idx == 2'd2;
      bus.ldSones <= keyOk & inLt & idx == 2'd3;
      bus.aMtens <= keyOk & inLa & idx == 2'd0;
      bus.aMones <= keyOk & inLa & idx == 2'd1;
      bus.aStens <= keyOk & inLa & idx == 2'd2;
      bus.aSones <= keyOk & inLa & idx == 2'd3;
      bus.dicSelectLEDdisp <= bus.cmd_next;
      bus.err_digit <= keyBad;
    end
  end
endmodule

// File: tb/tb_dic_ctrl.sv
// tb_dic_ctrl: directed and random stimulus checked every cycle against a mode/digit-index reference model.
module tb_dic_ctrl;
  logic clk = 0;
  logic rst = 1;
  int nTests = 0;
  int nFail = 0;
  int mMode = 0;
  int mIdx = 0;
  int mRet = 0;
  int mSecs = 0;
  bit mArmed = 0;
  dic_ctrl_if bus ();
  dic_ctrl dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    nTests++;
    if (got !== exp) begin
      nFail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic clearIn();
    {bus.cmd_run, bus.cmd_stop, bus.cmd_load, bus.cmd_alarm, bus.cmd_abort, bus.cmd_ack, bus.cmd_next} = '0;
    bus.key_strb = 0;
    bus.key_digit = 0;
    bus.i_oneSecStrb = 0;
    bus.alarm_triggered = 0;
  endtask
  task automatic step();
    logic [7:0] eP, gP;
    logic [3:0] eN;
    bit eR, eD, eE, done, newArmed;
    eP = 0; eN = 0; eE = 0; eD = 0; done = 0;
    if (rst) begin
      mMode = 0; mIdx = 0; mRet = 0; mSecs = 0; mArmed = 0;
    end else begin
      eD = bus.cmd_next;
      if (mMode >= 2) begin
        if (bus.cmd_abort) mMode = (mMode == 3) ? mRet : 0;
        else if (bus.key_strb) begin
          if (int'(bus.key_digit) <= ((mIdx % 2 == 0) ? 5 : 9)) begin
            eP[(mMode == 3 ? 4 : 0) + mIdx] = 1;
            eN = bus.key_digit;
            mIdx++;
            if (mIdx == 4) begin
              done = mMode == 3;
              mMode = done ? mRet : 0;
            end
          end else eE = 1;
        end
      end else if (bus.cmd_load) begin
        mMode = 2; mIdx = 0;
      end else if (bus.cmd_alarm) begin
        mRet = mMode; mMode = 3; mIdx = 0;
      end else if (mMode == 0 && bus.cmd_run) mMode = 1;
      else if (mMode == 1 && bus.cmd_stop) mMode = 0;
      if (mArmed && bus.alarm_triggered && bus.i_oneSecStrb) mSecs++;
      newArmed = done || (mArmed && !bus.cmd_ack && mSecs < 30);
      if (!(mArmed && newArmed) || mSecs == 30) mSecs = 0;
      mArmed = newArmed;
    end
    eR = mMode == 1 || (mMode == 3 && mRet == 1);
    gP = {bus.aSones, bus.aStens, bus.aMones, bus.aMtens, bus.ldSones, bus.ldStens, bus.ldMones, bus.ldMtens};
    chk("pulses", gP, eP);
    chk("ld_num", 8'(bus.ld_num), 8'(eN));
    chk("dicRun", 8'(bus.dicRun), 8'(eR));
    chk("alarm_ena", 8'(bus.alarm_ena), 8'(mArmed));
    chk("ledSel", 8'(bus.dicSelectLEDdisp), 8'(eD));
    chk("err_digit", 8'(bus.err_digit), 8'(eE));
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
    step();
    clearIn();
  endtask
  task automatic key(input logic [3:0] d);
    bus.key_strb = 1;
    bus.key_digit = d;
    tick();
  endtask
  function automatic bit p(input int n);
    return $urandom_range(0, n - 1) == 0;
  endfunction
  initial begin
    clearIn();
    tick();
    rst = 0;
    bus.cmd_load = 1; tick();
    key(1); key(2); key(3); key(4);
    bus.cmd_run = 1; tick();
    chk("runAfterLoad", 8'(bus.dicRun), 8'd1);
    bus.cmd_alarm = 1; tick();
    key(0); key(0); key(0); key(7);
    chk("armedAfterAlarm", 8'(bus.alarm_ena), 8'd1);
    for (int i = 0; i < 30; i++) begin
      bus.alarm_triggered = 1; bus.i_oneSecStrb = 1; tick();
    end
    chk("autoDisarm", 8'(bus.alarm_ena), 8'd0);
    bus.cmd_alarm = 1; tick();
    key(1); key(2); key(3); key(4);
    for (int i = 0; i < 10; i++) begin
      bus.alarm_triggered = 1; bus.i_oneSecStrb = 1; tick();
    end
    bus.cmd_ack = 1; tick();
    chk("ackDisarm", 8'(bus.alarm_ena), 8'd0);
    bus.cmd_load = 1; tick();
    key(6); key(5);
    bus.cmd_abort = 1; tick();
    bus.cmd_alarm = 1; tick();
    key(2);
    bus.cmd_abort = 1; bus.key_strb = 1; bus.key_digit = 3; tick();
    bus.cmd_load = 1; tick();
    key(1); key(9);
    rst = 1; bus.key_strb = 1; bus.key_digit = 4; bus.cmd_next = 1; tick();
    rst = 0;
    bus.cmd_next = 1; tick();
    bus.cmd_run = 1; tick();
    bus.cmd_next = 1; tick();
    for (int c = 0; c < 20000; c++) begin
      rst = p(500);
      bus.cmd_abort = p(40);
      bus.cmd_load = p(30);
      bus.cmd_alarm = p(20);
      bus.cmd_run = p(8);
      bus.cmd_stop = p(16);
      bus.cmd_ack = p(200);
      bus.cmd_next = p(10);
      bus.key_strb = p(3);
      bus.key_digit = p(6) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 9));
      bus.i_oneSecStrb = p(2);
      bus.alarm_triggered = !p(10);
      tick();
    end
    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end
endmodule

// File: doc/dic_ctrl.md
DIC_CTRL -- requirements
Module: dic_ctrl

Interface
REQ-001 clk  in  1  system clock; all state changes on rising edge.
REQ-002 rst  in  1  synchronous, active-high reset.
REQ-003 cmd_run / cmd_stop / cmd_load / cmd_alarm / cmd_abort / cmd_ack / cmd_next  in  1 each  one-cycle key-command strobes.
REQ-004 key_strb  in  1  one-cycle strobe; key_digit is valid while it is high.
REQ-005 key_digit  in  4  decoded digit value.
REQ-006 i_oneSecStrb  in  1  one-cycle strobe per second.
REQ-007 alarm_triggered  in  1  alarm-match indication from the clock datapath.
REQ-008 ldMtens, ldMones, ldStens, ldSones  out  1 each  time-digit load pulses.
REQ-009 aMtens, aMones, aStens, aSones  out  1 each  alarm-digit load pulses.
REQ-010 ld_num  out  4  digit value accompanying any load pulse.
REQ-011 dicRun  out  1  1 = clock counts, 0 = frozen.
REQ-012 alarm_ena  out  1  alarm armed.
REQ-013 dicSelectLEDdisp  out  1  one-cycle LED-digit advance pulse.
REQ-014 err_digit  out  1  one-cycle pulse on a rejected digit.
REQ-015 All outputs SHALL be registered.

Function
REQ-016 FSM states: STOP, RUN, LT_MT, LT_MO, LT_ST, LT_SO (time load), LA_MT, LA_MO, LA_ST, LA_SO (alarm load).
REQ-017 STOP + cmd_run -> RUN; RUN + cmd_stop -> STOP.
REQ-018 STOP/RUN + cmd_load -> LT_MT; dicRun SHALL be 0 from the next cycle through the whole time-load sequence.
REQ-019 STOP/RUN + cmd_alarm -> LA_MT; a 1-bit ret_run register SHALL capture RUN (1) or STOP (0) at entry, and dicRun SHALL keep that value during alarm load.
REQ-020 Load order SHALL be Mtens -> Mones -> Stens -> Sones; each accepted key_strb advances one state.
REQ-021 Digit legality: tens digits 0-5, ones digits 0-9.
- Illegal digit: no load pulse; err_digit pulses the next cycle; state unchanged.
REQ-022 Accepted digit: the matching ld*/a* pulse SHALL be high for exactly one cycle, the cycle after key_strb, with ld_num = key_digit in that same cycle.
REQ-023 ld_num SHALL be 0 whenever no load pulse is high.
REQ-024 At most one of the eight load pulses SHALL be high in any cycle.
REQ-025 Sequence completion:
- Digit accepted in LT_SO -> STOP (clock stays frozen until cmd_run).
- Digit accepted in LA_SO -> the state recorded in ret_run, and alarm_ena SHALL be set to 1.
REQ-026 cmd_abort in any load state:
- Time load -> STOP.
- Alarm load -> the state recorded in ret_run.
- Digits already loaded are kept; alarm_ena is unchanged.
REQ-027 cmd_abort, cmd_load and cmd_alarm SHALL be ignored in any state where REQ-017..026 assign them no transition.
REQ-028 Same-cycle command priority: cmd_abort > cmd_load > cmd_alarm > cmd_run/cmd_stop.
- A key_strb arriving with any state-changing command SHALL be dropped, with no err_digit.
REQ-029 cmd_ack SHALL clear alarm_ena in any state and does not affect the FSM.
- If cmd_ack coincides with LA_SO completion, completion wins and alarm_ena = 1.
REQ-030 cmd_next SHALL produce one dicSelectLEDdisp pulse the next cycle, in any state.
REQ-031 Auto-disarm timer:
- 5-bit counter increments on i_oneSecStrb while alarm_ena & alarm_triggered.
- On reaching 30 it SHALL clear alarm_ena and zero itself.
- It SHALL also zero whenever alarm_ena = 0, and saturates at no other value.

Reset
REQ-032 While rst is high at a clock edge, all of the following SHALL hold the next cycle:
- State = STOP; ret_run = 0; counter = 0.
- dicRun = 0, alarm_ena = 0, ld_num = 0.
- All load pulses, dicSelectLEDdisp and err_digit = 0.
REQ-033 rst SHALL override every command and key_strb in the same cycle, including mid-load; partially loaded digits are abandoned.

Verification
REQ-034 rst; cmd_load; digits 1,2,3,4 -> ldMtens/ld_num=1, ldMones/2, ldStens/3, ldSones/4, each one cycle after its strobe; final state STOP, dicRun=0; cmd_run -> dicRun=1.
REQ-035 RUN; cmd_alarm; digits 0,0,0,7 -> dicRun stays 1 throughout; aMtens..aSones pulses with 0,0,0,7; returns to RUN; alarm_ena=1.
REQ-036 LT_MT; digit 6 -> err_digit one pulse, no load pulse, stays LT_MT; then digit 5 -> ldMtens, ld_num=5.
REQ-037 alarm_ena=1, alarm_triggered=1, 30 i_oneSecStrb -> alarm_ena=0 the cycle after the 30th; repeat with cmd_ack after 10 strobes -> alarm_ena=0 immediately, counter=0.
REQ-038 LA_MO with cmd_abort and key_strb in the same cycle -> no load pulse, no err_digit, returns to the ret_run state.
REQ-039 rst asserted in LT_ST -> STOP, all outputs 0.
REQ-040 cmd_next alone, in STOP and in RUN -> one dicSelectLEDdisp pulse each time.
